retire_unit: RTL and testbench

In-order commit stage for the dual-issue out-of-order core. It reads the two oldest Reorder Buffer head entries, which Rename/Dispatch write at the tail, and pops them from the ROB. It maintains the retirement (architectural) RAT and returns superseded physical registers to the Freelist. On a mispredicted branch at retirement it raises a one-cycle flush with a redirect address and exposes the retirement RAT so Front_RAT can be restored.

---
 rtl/retire_unit_if.sv | 51 +++++
 rtl/retire_unit.sv | 111 +++++++++++
 tb/tb_retire_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/retire_unit_if.sv
// ROB-head / retire-unit bundle: head entries in, retire pops, frees, flush and RRAT out.
// The ROB/Front_RAT side uses the master modport and the retire unit uses the slave modport.
interface retire_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PHY_WIDTH  = 6
);
  logic [1:0]                      head_valid;
  logic [1:0]                      head_done;
  logic                            head_has_rd_0;
  logic                            head_has_rd_1;
  logic [4:0]                      head_rd_arch_0;
  logic [4:0]                      head_rd_arch_1;
  logic [PHY_WIDTH-1:0]            head_rd_phy_0;
  logic [PHY_WIDTH-1:0]            head_rd_phy_1;
  logic [PHY_WIDTH-1:0]            head_rd_phy_old_0;
  logic [PHY_WIDTH-1:0]            head_rd_phy_old_1;
  logic                            head_mispredict_0;
  logic                            head_mispredict_1;
  logic [ADDR_WIDTH-1:0]           head_target_0;
  logic [ADDR_WIDTH-1:0]           head_target_1;

  logic [1:0]                      retire_valid;
  logic [1:0]                      free_valid;
  logic [PHY_WIDTH-1:0]            free_phy_0;
  logic [PHY_WIDTH-1:0]            free_phy_1;
  logic                            flush;
  logic                            redirect_valid;
  logic [ADDR_WIDTH-1:0]           redirect_addr;
  logic [ARCH_REGS*PHY_WIDTH-1:0]  rrat_snapshot;
  logic [31:0]                     retired_count;
  logic [31:0]                     flush_count;

  modport master (
    output head_valid, head_done, head_has_rd_0, head_has_rd_1,
           head_rd_arch_0, head_rd_arch_1, head_rd_phy_0, head_rd_phy_1,
           head_rd_phy_old_0, head_rd_phy_old_1, head_mispredict_0, head_mispredict_1,
           head_target_0, head_target_1,
    input  retire_valid, free_valid, free_phy_0, free_phy_1, flush, redirect_valid,
           redirect_addr, rrat_snapshot, retired_count, flush_count
  );

  modport slave (
    input  head_valid, head_done, head_has_rd_0, head_has_rd_1,
           head_rd_arch_0, head_rd_arch_1, head_rd_phy_0, head_rd_phy_1,
           head_rd_phy_old_0, head_rd_phy_old_1, head_mispredict_0, head_mispredict_1,
           head_target_0, head_target_1,
    output retire_valid, free_valid, free_phy_0, free_phy_1, flush, redirect_valid,
           redirect_addr, rrat_snapshot, retired_count, flush_count
  );
endinterface

// File: rtl/retire_unit.sv
// Dual-slot in-order commit: pops ROB head, updates retirement RAT, frees old regs, flushes on mispredict.
// Optional RETIRE_PERF_EN builds retired/flush performance counters; otherwise they read as 0.
module retire_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PHY_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst,
  retire_unit_if.slave  rob
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  redirect_q, redirect_d;
  logic [1:0]             retire_c;
  logic [1:0]             wr_c;
  logic [1:0]             free_valid_q;
  logic [PHY_WIDTH-1:0]   free_phy_0_q, free_phy_1_q;
  logic [PHY_WIDTH-1:0]   rrat_q [ARCH_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  // Retire selection and mispredict detection; FLUSH always returns to RUN.
  always_comb begin
    state_d    = state_q;
    redirect_d = redirect_q;
    retire_c   = 2'b00;
    unique case (state_q)
      RUN: begin
        retire_c[0] = rob.head_valid[0] & rob.head_done[0];
        retire_c[1] = retire_c[0] & ~rob.head_mispredict_0 &
                      rob.head_valid[1] & rob.head_done[1];
        if (retire_c[0] && rob.head_mispredict_0) begin
          state_d    = FLUSH;
          redirect_d = rob.head_target_0;
        end else if (retire_c[1] && rob.head_mispredict_1) begin
          state_d    = FLUSH;
          redirect_d = rob.head_target_1;
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Architectural register 0 is never remapped nor freed.
  assign wr_c[0] = retire_c[0] & rob.head_has_rd_0 & (rob.head_rd_arch_0 != 5'd0);
  assign wr_c[1] = retire_c[1] & rob.head_has_rd_1 & (rob.head_rd_arch_1 != 5'd0);

  // Slot 1 is written last so it wins a same-register collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rrat_q[i] <= PHY_WIDTH'(i);
      free_valid_q <= 2'b00;
      free_phy_0_q <= '0;
      free_phy_1_q <= '0;
    end else begin
      if (wr_c[0]) rrat_q[rob.head_rd_arch_0] <= rob.head_rd_phy_0;
      if (wr_c[1]) rrat_q[rob.head_rd_arch_1] <= rob.head_rd_phy_1;
      free_valid_q <= wr_c;
      free_phy_0_q <= wr_c[0] ? rob.head_rd_phy_old_0 : '0;
      free_phy_1_q <= wr_c[1] ? rob.head_rd_phy_old_1 : '0;
    end
  end

  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_snap
    assign rob.rrat_snapshot[g*PHY_WIDTH +: PHY_WIDTH] = rrat_q[g];
  end

  assign rob.retire_valid   = retire_c;
  assign rob.free_valid     = free_valid_q;
  assign rob.free_phy_0     = free_phy_0_q;
  assign rob.free_phy_1     = free_phy_1_q;
  assign rob.flush          = (state_q == FLUSH);
  assign rob.redirect_valid = (state_q == FLUSH);
  assign rob.redirect_addr  = redirect_q;

`ifdef RETIRE_PERF_EN
  logic        enter_flush_c;
  logic [31:0] retired_q, flushes_q;

  assign enter_flush_c = (state_q == RUN) && (state_d == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      flushes_q <= '0;
    end else begin
      retired_q <= retired_q + 32'(retire_c[0]) + 32'(retire_c[1]);
      flushes_q <= flushes_q + 32'(enter_flush_c);
    end
  end

  assign rob.retired_count = retired_q;
  assign rob.flush_count   = flushes_q;
`else
  assign rob.retired_count = 32'd0;
  assign rob.flush_count   = 32'd0;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: queue/array commit model checked every cycle plus directed literal checks.
module tb_retire_unit;
  localparam int unsigned AW = 32;
  localparam int unsigned AR = 32;
  localparam int unsigned PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   run_cmp = 1'b0;

  always #5 clk = ~clk;

  retire_unit_if #(.ADDR_WIDTH(AW), .ARCH_REGS(AR), .PHY_WIDTH(PW)) rob ();
  retire_unit #(.ADDR_WIDTH(AW), .ARCH_REGS(AR), .PHY_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .rob(rob)
  );

  // Commit model: mapping table, pending redirect, last-cycle frees and counters.
  int          rrat_m [AR];
  bit          flush_m;
  logic [31:0] redir_m;
  logic [1:0]  fv_m;
  int          fp_m [2];
  longint      retired_m, flushes_m;

  function automatic logic [1:0] model_retire();
    logic [1:0] r;
    r = 2'b00;
    if (!flush_m && !rst) begin
      if (rob.head_valid[0] && rob.head_done[0]) begin
        r[0] = 1'b1;
        if (!rob.head_mispredict_0 && rob.head_valid[1] && rob.head_done[1]) r[1] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AR; i++) rrat_m[i] = i;
      flush_m = 0; redir_m = '0; fv_m = 2'b00; fp_m[0] = 0; fp_m[1] = 0;
      retired_m = 0; flushes_m = 0;
    end else begin
      logic [1:0] r;
      bit         was_flush;
      r = model_retire();
      was_flush = flush_m;
      fv_m = 2'b00;
      if (r[0] && rob.head_has_rd_0 && rob.head_rd_arch_0 != 0) begin
        rrat_m[rob.head_rd_arch_0] = rob.head_rd_phy_0; fv_m[0] = 1; fp_m[0] = rob.head_rd_phy_old_0;
      end
      if (r[1] && rob.head_has_rd_1 && rob.head_rd_arch_1 != 0) begin
        rrat_m[rob.head_rd_arch_1] = rob.head_rd_phy_1; fv_m[1] = 1; fp_m[1] = rob.head_rd_phy_old_1;
      end
      retired_m += r[0] + r[1];
      flush_m = 0;
      if (!was_flush) begin
        if (r[0] && rob.head_mispredict_0) begin flush_m = 1; redir_m = rob.head_target_0; end
        else if (r[1] && rob.head_mispredict_1) begin flush_m = 1; redir_m = rob.head_target_1; end
        if (flush_m) flushes_m++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] snap(input int i);
    logic [AR*PW-1:0] v;
    v = rob.rrat_snapshot;
    return v[i*PW +: PW];
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      logic [AR*PW-1:0] exp_snap;
      logic [31:0] exp_rc, exp_fc;
      for (int i = 0; i < AR; i++) exp_snap[i*PW +: PW] = PW'(rrat_m[i]);
      chk("m_retire_valid", 64'(rob.retire_valid), 64'(model_retire()));
      chk("m_free_valid", 64'(rob.free_valid), 64'(fv_m));
      if (fv_m[0]) chk("m_free_phy_0", 64'(rob.free_phy_0), 64'(fp_m[0]));
      if (fv_m[1]) chk("m_free_phy_1", 64'(rob.free_phy_1), 64'(fp_m[1]));
      chk("m_flush", 64'(rob.flush), 64'(flush_m));
      chk("m_redirect_valid", 64'(rob.redirect_valid), 64'(flush_m));
      if (flush_m) chk("m_redirect_addr", 64'(rob.redirect_addr), 64'(redir_m));
      checks++;
      if (rob.rrat_snapshot !== exp_snap) begin
        errors++;
        $display("FAIL m_rrat_snapshot actual=%h expected=%h", rob.rrat_snapshot, exp_snap);
      end
`ifdef RETIRE_PERF_EN
      exp_rc = 32'(retired_m); exp_fc = 32'(flushes_m);
`else
      exp_rc = 32'd0; exp_fc = 32'd0;
`endif
      chk("m_retired_count", 64'(rob.retired_count), 64'(exp_rc));
      chk("m_flush_count", 64'(rob.flush_count), 64'(exp_fc));
    end
  end

  task automatic idle();
    rob.head_valid = 2'b00; rob.head_done = 2'b00;
    rob.head_has_rd_0 = 0; rob.head_has_rd_1 = 0;
    rob.head_rd_arch_0 = '0; rob.head_rd_arch_1 = '0;
    rob.head_rd_phy_0 = '0; rob.head_rd_phy_1 = '0;
    rob.head_rd_phy_old_0 = '0; rob.head_rd_phy_old_1 = '0;
    rob.head_mispredict_0 = 0; rob.head_mispredict_1 = 0;
    rob.head_target_0 = '0; rob.head_target_1 = '0;
  endtask

  task automatic slot(input int k, input bit v, input bit d, input bit has, input int arch,
                      input int phy, input int old, input bit mp, input logic [31:0] tgt);
    rob.head_valid[k] = v; rob.head_done[k] = d;
    if (k == 0) begin
      rob.head_has_rd_0 = has; rob.head_rd_arch_0 = 5'(arch); rob.head_rd_phy_0 = PW'(phy);
      rob.head_rd_phy_old_0 = PW'(old); rob.head_mispredict_0 = mp; rob.head_target_0 = tgt;
    end else begin
      rob.head_has_rd_1 = has; rob.head_rd_arch_1 = 5'(arch); rob.head_rd_phy_1 = PW'(phy);
      rob.head_rd_phy_old_1 = PW'(old); rob.head_mispredict_1 = mp; rob.head_target_1 = tgt;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_one;
`ifdef RETIRE_PERF_EN
    exp_one = 32'd1;
`else
    exp_one = 32'd0;
`endif
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_cmp = 1'b1;
    #1;
    chk("rst_retire_valid", 64'(rob.retire_valid), 64'd0);
    chk("rst_flush", 64'(rob.flush), 64'd0);
    chk("rst_rrat5", 64'(snap(5)), 64'd5);
    chk("rst_free_valid", 64'(rob.free_valid), 64'd0);

    // Slot 0 mispredict with slot 1 done: only slot 0 retires, then one flush cycle.
    tick();
    slot(0, 1, 1, 1, 5, 30, 5, 1, 32'h100);
    slot(1, 1, 1, 1, 6, 31, 6, 0, 32'h0);
    #1 chk("mp_retire_valid", 64'(rob.retire_valid), 64'b01);
    tick();
    chk("mp_flush", 64'(rob.flush), 64'd1);
    chk("mp_redirect_addr", 64'(rob.redirect_addr), 64'h100);
    chk("mp_retire_blocked", 64'(rob.retire_valid), 64'b00);
    chk("mp_rrat5", 64'(snap(5)), 64'd30);
    chk("mp_rrat6", 64'(snap(6)), 64'd6);
    idle();
    tick();
    chk("mp_flush_done", 64'(rob.flush), 64'd0);
    chk("mp_flush_count", 64'(rob.flush_count), 64'(exp_one));
    chk("mp_retired_count", 64'(rob.retired_count), 64'(exp_one));

    // Dual retire to registers 3 and 4.
    slot(0, 1, 1, 1, 3, 40, 3, 0, 32'h0);
    slot(1, 1, 1, 1, 4, 41, 4, 0, 32'h0);
    #1 chk("dual_retire_valid", 64'(rob.retire_valid), 64'b11);
    tick();
    idle();
    chk("dual_free_valid", 64'(rob.free_valid), 64'b11);
    chk("dual_free_phy_0", 64'(rob.free_phy_0), 64'd3);
    chk("dual_free_phy_1", 64'(rob.free_phy_1), 64'd4);
    chk("dual_rrat3", 64'(snap(3)), 64'd40);
    chk("dual_rrat4", 64'(snap(4)), 64'd41);

    // Slot 1 done without slot 0: in-order commit blocks both.
    slot(0, 1, 0, 1, 9, 20, 9, 0, 32'h0);
    slot(1, 1, 1, 1, 10, 21, 10, 0, 32'h0);
    #1 chk("order_retire_valid", 64'(rob.retire_valid), 64'b00);
    tick();
    chk("order_rrat10", 64'(snap(10)), 64'd10);
    chk("order_free_valid", 64'(rob.free_valid), 64'b00);

    // Same destination in both slots: slot 1 mapping wins, both olds freed.
    slot(0, 1, 1, 1, 7, 50, 7, 0, 32'h0);
    slot(1, 1, 1, 1, 7, 51, 50, 0, 32'h0);
    tick();
    idle();
    chk("waw_rrat7", 64'(snap(7)), 64'd51);
    chk("waw_free_phy_0", 64'(rob.free_phy_0), 64'd7);
    chk("waw_free_phy_1", 64'(rob.free_phy_1), 64'd50);

    // rd_arch 0 with has_rd set is neither mapped nor freed.
    slot(0, 1, 1, 1, 0, 60, 12, 0, 32'h0);
    slot(1, 1, 1, 1, 8, 61, 8, 0, 32'h0);
    tick();
    idle();
    chk("x0_free_valid", 64'(rob.free_valid), 64'b10);
    chk("x0_rrat0", 64'(snap(0)), 64'd0);
    chk("x0_rrat8", 64'(snap(8)), 64'd61);

    // Slot 1 mispredict: both retire, redirect to slot 1 target; reset during FLUSH.
    slot(0, 1, 1, 1, 11, 33, 11, 0, 32'h0);
    slot(1, 1, 1, 1, 12, 34, 12, 1, 32'h200);
    #1 chk("mp1_retire_valid", 64'(rob.retire_valid), 64'b11);
    tick();
    idle();
    chk("mp1_flush", 64'(rob.flush), 64'd1);
    chk("mp1_redirect_addr", 64'(rob.redirect_addr), 64'h200);
    rst = 1'b1;
    #1;
    chk("rstf_flush", 64'(rob.flush), 64'd0);
    chk("rstf_redirect_valid", 64'(rob.redirect_valid), 64'd0);
    chk("rstf_rrat3", 64'(snap(3)), 64'd3);
    chk("rstf_rrat12", 64'(snap(12)), 64'd12);
    chk("rstf_redirect_addr", 64'(rob.redirect_addr), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_flush", 64'(rob.flush), 64'd0);

    // A few mixed cycles checked by the model only.
    for (int i = 0; i < 12; i++) begin
      slot(0, 1'(i % 3 != 2), 1'(i % 4 != 3), 1'(i % 2), 1 + i, 20 + i, 1 + i, 1'(i == 5), 32'(16 * i));
      slot(1, 1, 1'(i % 2 == 0), 1, 2 + i, 40 + i, 2 + i, 1'(i == 8), 32'(32 * i));
      tick();
    end
    idle();
    repeat (3) tick();
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
